// File: rtl/k580vt57_pkg.sv
// Shared types and constants for the k580vt57 four-channel DMA controller.
package k580vt57_pkg;

  localparam int unsigned NumCh = 4;

  typedef enum logic [2:0] {
    StIdle,
    StHold,
    StS1,
    StS2,
    StS3,
    StS4
  } dma_state_e;

  // Mode register bit positions
  localparam int unsigned ModeEnLsb    = 0;
  localparam int unsigned ModeRot      = 4;
  localparam int unsigned ModeExtw     = 5;
  localparam int unsigned ModeTcStop   = 6;
  localparam int unsigned ModeAutoload = 7;

  // Transfer type held in count[15:14]
  localparam logic [1:0] XferVerify = 2'b00;
  localparam logic [1:0] XferWrite  = 2'b01;
  localparam logic [1:0] XferRead   = 2'b10;

  localparam logic [3:0] RegMode   = 4'd8;
  localparam logic [3:0] RegStatus = 4'd8;

  function automatic logic is_chan_reg(logic [3:0] a);
    return !a[3];
  endfunction

  function automatic logic [1:0] onehot_to_idx(logic [3:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/k580vt57_if.sv
// CPU register port and DMA bus signals of the k580vt57.
interface k580vt57_if;
  logic [3:0]  iaddr;
  logic [7:0]  idata;
  logic [7:0]  odata;
  logic        iwe_n;
  logic        ird_n;
  logic [3:0]  drq;
  logic [3:0]  dack;
  logic        hrq;
  logic        hlda;
  logic [15:0] oaddr;
  logic        memr_n;
  logic        memw_n;
  logic        ior_n;
  logic        iow_n;
  logic        tc;

  // slave: the DMA controller itself; master: the CPU/system side
  modport slave (
    input  iaddr, idata, iwe_n, ird_n, drq, hlda,
    output odata, dack, hrq, oaddr, memr_n, memw_n, ior_n, iow_n, tc
  );

  modport master (
    output iaddr, idata, iwe_n, ird_n, drq, hlda,
    input  odata, dack, hrq, oaddr, memr_n, memw_n, ior_n, iow_n, tc
  );
endinterface

// File: rtl/dma_prio_arb.sv
// Four-way priority encoder; fixed (ch0 first) or rotating after the last-serviced channel.
module dma_prio_arb (
  input  logic [3:0] req_i,
  input  logic       rot_i,
  input  logic [1:0] last_i,
  output logic [3:0] gnt_o
);

  logic       found;
  logic [1:0] idx;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < 4; i++) begin
      idx = rot_i ? last_i + 2'(i + 1) : 2'(i);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/k580vt57.sv
// K580VT57 / i8257-compatible DMA controller: register file, transfer FSM and bus strobes.
module k580vt57
  import k580vt57_pkg::*;
(
  input logic       clk,
  input logic       reset_n,
  k580vt57_if.slave bus
);

  logic [15:0] addr_q [NumCh];
  logic [15:0] addr_d [NumCh];
  logic [15:0] cnt_q  [NumCh];
  logic [15:0] cnt_d  [NumCh];
  logic [7:0]  mode_q, mode_d;
  logic [3:0]  tcf_q, tcf_d;
  logic        upd_q, upd_d;
  logic        ff_q, ff_d;
  logic        we_q, rd_q;
  dma_state_e  state_q, state_d;
  logic [1:0]  act_q, act_d;
  logic        tc_q, tc_d;

  logic        wr_fire, rd_fire, mirror, start, busy;
  logic [1:0]  wch, gnt_idx, typ;
  logic [3:0]  req, gnt;
  logic [15:0] rd_val;

  assign wr_fire = bus.iwe_n & ~we_q;
  assign rd_fire = bus.ird_n & ~rd_q;
  assign wch     = bus.iaddr[2:1];
  assign mirror  = mode_q[ModeAutoload] && (wch == 2'd2);

  // Register file next state: status clear, then S4 update, then CPU write on top
  always_comb begin
    addr_d = addr_q;
    cnt_d  = cnt_q;
    mode_d = mode_q;
    tcf_d  = tcf_q;
    upd_d  = upd_q;
    ff_d   = ff_q;

    if (rd_fire) begin
      if (is_chan_reg(bus.iaddr)) begin
        ff_d = ~ff_q;
      end else if (bus.iaddr == RegStatus) begin
        tcf_d = '0;
        upd_d = 1'b0;
      end
    end

    if (state_q == StS4) begin
      addr_d[act_q] = addr_q[act_q] + 16'd1;
      cnt_d[act_q]  = {cnt_q[act_q][15:14], cnt_q[act_q][13:0] - 14'd1};
      if (tc_q) begin
        tcf_d[act_q] = 1'b1;
        if (mode_q[ModeTcStop]) mode_d[act_q] = 1'b0;
        if (act_q == 2'd2 && mode_q[ModeAutoload]) begin
          addr_d[2] = addr_q[3];
          cnt_d[2]  = cnt_q[3];
          upd_d     = 1'b1;
        end
      end
    end

    if (wr_fire) begin
      if (is_chan_reg(bus.iaddr)) begin
        for (int c = 0; c < NumCh; c++) begin
          if (2'(c) == wch || (c == 3 && mirror)) begin
            if (bus.iaddr[0]) begin
              if (ff_q) cnt_d[c][15:8] = bus.idata;
              else      cnt_d[c][7:0]  = bus.idata;
            end else begin
              if (ff_q) addr_d[c][15:8] = bus.idata;
              else      addr_d[c][7:0]  = bus.idata;
            end
          end
        end
        ff_d = ~ff_q;
      end else if (bus.iaddr == RegMode) begin
        mode_d = bus.idata;
        ff_d   = 1'b0;
      end
    end
  end

  // Enables already reflect a TC-stop clear in this S4, so a stopped channel never bursts on
  assign req = bus.drq & mode_d[ModeEnLsb +: NumCh];

  dma_prio_arb u_arb (
    .req_i  (req),
    .rot_i  (mode_q[ModeRot]),
    .last_i (act_q),
    .gnt_o  (gnt)
  );

  assign gnt_idx = onehot_to_idx(gnt);

  always_comb begin
    state_d = state_q;
    act_d   = act_q;
    tc_d    = tc_q;
    start   = 1'b0;
    unique case (state_q)
      StIdle: if (|req) state_d = StHold;
      StHold: begin
        if (!(|req))       state_d = StIdle;
        else if (bus.hlda) start   = 1'b1;
      end
      StS1: state_d = StS2;
      StS2: state_d = StS3;
      StS3: state_d = StS4;
      StS4: begin
        if (bus.hlda && (|req)) start   = 1'b1;
        else                    state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (start) begin
      state_d = StS1;
      act_d   = gnt_idx;
      tc_d    = (cnt_d[gnt_idx][13:0] == 14'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int c = 0; c < NumCh; c++) begin
        addr_q[c] <= '0;
        cnt_q[c]  <= '0;
      end
      mode_q  <= '0;
      tcf_q   <= '0;
      upd_q   <= 1'b0;
      ff_q    <= 1'b0;
      we_q    <= 1'b1;
      rd_q    <= 1'b1;
      state_q <= StIdle;
      act_q   <= 2'd3;
      tc_q    <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      tcf_q   <= tcf_d;
      upd_q   <= upd_d;
      ff_q    <= ff_d;
      we_q    <= bus.iwe_n;
      rd_q    <= bus.ird_n;
      state_q <= state_d;
      act_q   <= act_d;
      tc_q    <= tc_d;
    end
  end

  always_comb begin
    rd_val    = bus.iaddr[0] ? cnt_q[wch] : addr_q[wch];
    bus.odata = '0;
    if (is_chan_reg(bus.iaddr)) begin
      bus.odata = ff_q ? rd_val[15:8] : rd_val[7:0];
    end else if (bus.iaddr == RegStatus) begin
      bus.odata = {3'b000, upd_q, tcf_q};
    end
  end

  assign busy = (state_q == StS1) || (state_q == StS2) || (state_q == StS3) ||
                (state_q == StS4);
  // Mode 11 behaves as verify
  assign typ  = (cnt_q[act_q][15:14] == 2'b11) ? XferVerify : cnt_q[act_q][15:14];

  logic mid, early;
  assign mid   = (state_q == StS2) || (state_q == StS3);
  assign early = (state_q == StS1) && mode_q[ModeExtw];

  assign bus.hrq    = (state_q != StIdle);
  assign bus.dack   = busy ? (4'b0001 << act_q) : 4'b0000;
  assign bus.oaddr  = busy ? addr_q[act_q] : 16'h0000;
  assign bus.tc     = busy & tc_q;
  assign bus.memr_n = !(mid && typ == XferRead);
  assign bus.iow_n  = !((mid || early) && typ == XferRead);
  assign bus.memw_n = !((mid || early) && typ == XferWrite);
  assign bus.ior_n  = !(mid && typ == XferWrite);

endmodule
